// File: rtl/rv32.sv
// rv32: shared trap types, CSR addresses, mstatus/mip bit positions
// and exception/interrupt cause codes used by the trap controller.
package rv32;

    typedef logic [11:0] csr_addr_t;

    typedef enum logic [1:0] {
        UMODE = 2'b00,
        MMODE = 2'b11
    } priv_mode_t;

    typedef struct packed {
        logic        intr;
        logic [30:0] code;
    } trap_cause_t;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LSB  = 11;

    localparam int MIP_MSI = 3;
    localparam int MIP_MTI = 7;
    localparam int MIP_MEI = 11;

    localparam logic [3:0] TRAP_CODE_INSN_MISALIGN = 4'd0;
    localparam logic [3:0] TRAP_CODE_INSN_FAULT    = 4'd1;
    localparam logic [3:0] TRAP_CODE_ILLEGAL_INSN  = 4'd2;
    localparam logic [3:0] TRAP_CODE_BREAKPOINT    = 4'd3;
    localparam logic [3:0] TRAP_CODE_LOAD_FAULT    = 4'd5;
    localparam logic [3:0] TRAP_CODE_STORE_FAULT   = 4'd7;
    localparam logic [3:0] TRAP_CODE_ECALL_U       = 4'd8;
    localparam logic [3:0] TRAP_CODE_ECALL_M       = 4'd11;

    localparam logic [3:0] TRAP_CODE_MSI = 4'd3;
    localparam logic [3:0] TRAP_CODE_MTI = 4'd7;
    localparam logic [3:0] TRAP_CODE_MEI = 4'd11;

    localparam csr_addr_t CSR_MSTATUS = 12'h300;
    localparam csr_addr_t CSR_MIE     = 12'h304;
    localparam csr_addr_t CSR_MTVEC   = 12'h305;
    localparam csr_addr_t CSR_MEPC    = 12'h341;
    localparam csr_addr_t CSR_MCAUSE  = 12'h342;
    localparam csr_addr_t CSR_MTVAL   = 12'h343;
    localparam csr_addr_t CSR_MIP     = 12'h344;

endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: picks the trap to take for the committing instruction.
// Ports: i_exc_valid/i_exc_code, i_pend/i_en {MEI,MTI,MSI}, i_gie -> o_take, o_cause.
import rv32::*;

module trap_prio_enc (
    input  logic        i_exc_valid,
    input  logic [3:0]  i_exc_code,
    input  logic [2:0]  i_pend,
    input  logic [2:0]  i_en,
    input  logic        i_gie,
    output logic        o_take,
    output trap_cause_t o_cause
);

    logic [2:0] w_elig;

    assign w_elig = i_pend & i_en & {3{i_gie}};

    // Exceptions beat interrupts; among interrupts MEI > MSI > MTI.
    always_comb begin
        o_take  = 1'b0;
        o_cause = '0;
        if (i_exc_valid) begin
            o_take       = 1'b1;
            o_cause.code = {27'b0, i_exc_code};
        end else if (w_elig[2]) begin
            o_take       = 1'b1;
            o_cause.intr = 1'b1;
            o_cause.code = {27'b0, TRAP_CODE_MEI};
        end else if (w_elig[0]) begin
            o_take       = 1'b1;
            o_cause.intr = 1'b1;
            o_cause.code = {27'b0, TRAP_CODE_MSI};
        end else if (w_elig[1]) begin
            o_take       = 1'b1;
            o_cause.intr = 1'b1;
            o_cause.code = {27'b0, TRAP_CODE_MTI};
        end
    end

endmodule

// File: rtl/trap_unit.sv
// trap_unit: machine-mode trap controller at commit. Owns mstatus, mie, mip,
// mtvec, mepc, mcause, mtval; emits a one-cycle redirect/stall and priv.
// Ports: clk, rst (async high); inst_valid/inst_pc, exc_valid/code/tval,
// mret, irq_msi/mti/mei; csr_addr/we/wdata -> csr_rdata, csr_hit;
// redirect, redirect_pc, stall, priv.
// Option: TRAP_VECTORED_EN enables vectored mtvec mode (01).
import rv32::*;

module trap_unit #(
    parameter logic [31:0] RESET_MTVEC   = 32'h0000_0100,
    parameter bit          SUPPORT_UMODE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [31:0] inst_pc,
    input  logic        exc_valid,
    input  logic [3:0]  exc_code,
    input  logic [31:0] exc_tval,
    input  logic        mret,
    input  logic        irq_msi,
    input  logic        irq_mti,
    input  logic        irq_mei,
    input  csr_addr_t   csr_addr,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_hit,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        stall,
    output priv_mode_t  priv
);

    typedef enum logic {S_IDLE, S_REDIRECT} state_t;

    state_t      r_state, w_state_nxt;
    priv_mode_t  r_priv, r_mpp;
    logic        r_mie_g, r_mpie;
    logic [2:0]  r_mie;
    logic [29:0] r_mtvec_base;
    logic [31:0] r_mepc, r_mtval, r_redirect_pc;
    trap_cause_t r_mcause;

    logic [1:0]  w_mtvec_mode;
    logic [2:0]  w_pend;
    logic        w_gie, w_take, w_accept, w_trap, w_mret, w_csr_wr;
    logic        w_mpp_ok;
    trap_cause_t w_cause;
    logic [31:0] w_base, w_vec, w_mstatus, w_mip, w_mie_rd;

`ifdef TRAP_VECTORED_EN
    logic r_mtvec_vec;
    assign w_mtvec_mode = {1'b0, r_mtvec_vec};
`else
    assign w_mtvec_mode = 2'b00;
`endif

    assign w_pend = {irq_mei, irq_mti, irq_msi};
    assign w_gie  = (r_priv != MMODE) | r_mie_g;

    trap_prio_enc u_prio (
        .i_exc_valid (exc_valid),
        .i_exc_code  (exc_code),
        .i_pend      (w_pend),
        .i_en        (r_mie),
        .i_gie       (w_gie),
        .o_take      (w_take),
        .o_cause     (w_cause)
    );

    assign w_accept = (r_state == S_IDLE) & inst_valid;
    assign w_trap   = w_accept & w_take;
    assign w_mret   = w_accept & mret & ~w_take;
    // A taken trap replaces the instruction, so its CSR write is lost.
    assign w_csr_wr = inst_valid & csr_we & ~w_trap;

    assign w_base = {r_mtvec_base, 2'b00};
    assign w_vec  = (w_mtvec_mode == 2'b01 && w_cause.intr)
                  ? w_base + {w_cause.code[29:0], 2'b00}
                  : w_base;

    assign w_mpp_ok = SUPPORT_UMODE &&
                      (csr_wdata[12:11] == 2'b00 || csr_wdata[12:11] == 2'b11);

    always_comb begin
        w_mstatus = '0;
        w_mstatus[MSTATUS_MIE_BIT]  = r_mie_g;
        w_mstatus[MSTATUS_MPIE_BIT] = r_mpie;
        w_mstatus[MSTATUS_MPP_LSB+:2] = r_mpp;
        w_mip = '0;
        w_mip[MIP_MSI] = irq_msi;
        w_mip[MIP_MTI] = irq_mti;
        w_mip[MIP_MEI] = irq_mei;
        w_mie_rd = '0;
        w_mie_rd[MIP_MSI] = r_mie[0];
        w_mie_rd[MIP_MTI] = r_mie[1];
        w_mie_rd[MIP_MEI] = r_mie[2];
    end

    always_comb begin
        csr_hit   = 1'b1;
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: csr_rdata = w_mstatus;
            CSR_MIE:     csr_rdata = w_mie_rd;
            CSR_MIP:     csr_rdata = w_mip;
            CSR_MTVEC:   csr_rdata = {r_mtvec_base, w_mtvec_mode};
            CSR_MEPC:    csr_rdata = r_mepc;
            CSR_MCAUSE:  csr_rdata = r_mcause;
            CSR_MTVAL:   csr_rdata = r_mtval;
            default:     csr_hit   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        redirect    = 1'b0;
        stall       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trap || w_mret) w_state_nxt = S_REDIRECT;
            end
            S_REDIRECT: begin
                redirect    = 1'b1;
                stall       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // mret/trap updates follow the CSR write so they override it;
    // mret reads r_mpie/r_mpp, i.e. the pre-write values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_priv        <= MMODE;
            r_mie_g       <= 1'b0;
            r_mpie        <= 1'b0;
            r_mpp         <= MMODE;
            r_mie         <= '0;
            r_mtvec_base  <= RESET_MTVEC[31:2];
            r_mepc        <= '0;
            r_mcause      <= '0;
            r_mtval       <= '0;
            r_redirect_pc <= '0;
`ifdef TRAP_VECTORED_EN
            r_mtvec_vec   <= 1'b0;
`endif
        end else begin
            if (w_csr_wr) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        r_mie_g <= csr_wdata[MSTATUS_MIE_BIT];
                        r_mpie  <= csr_wdata[MSTATUS_MPIE_BIT];
                        if (w_mpp_ok) r_mpp <= priv_mode_t'(csr_wdata[12:11]);
                    end
                    CSR_MIE: r_mie <= {csr_wdata[MIP_MEI],
                                       csr_wdata[MIP_MTI],
                                       csr_wdata[MIP_MSI]};
                    CSR_MTVEC: begin
                        r_mtvec_base <= csr_wdata[31:2];
`ifdef TRAP_VECTORED_EN
                        if (!csr_wdata[1]) r_mtvec_vec <= csr_wdata[0];
`endif
                    end
                    CSR_MEPC:   r_mepc   <= {csr_wdata[31:2], 2'b00};
                    CSR_MCAUSE: r_mcause <= csr_wdata;
                    CSR_MTVAL:  r_mtval  <= csr_wdata;
                    default: ;
                endcase
            end
            if (w_trap) begin
                r_mepc        <= {inst_pc[31:2], 2'b00};
                r_mcause      <= w_cause;
                r_mtval       <= w_cause.intr ? 32'b0 : exc_tval;
                r_mpie        <= r_mie_g;
                r_mie_g       <= 1'b0;
                r_mpp         <= SUPPORT_UMODE ? r_priv : MMODE;
                r_priv        <= MMODE;
                r_redirect_pc <= w_vec;
            end
            if (w_mret) begin
                r_mie_g       <= r_mpie;
                r_mpie        <= 1'b1;
                r_priv        <= SUPPORT_UMODE ? r_mpp : MMODE;
                r_mpp         <= SUPPORT_UMODE ? UMODE : MMODE;
                r_redirect_pc <= r_mepc;
            end
        end
    end

    assign redirect_pc = r_redirect_pc;
    assign priv        = r_priv;

endmodule

// File: tb/tb_trap_unit.sv
// tb_trap_unit: directed checks of trap_unit (reset, exceptions,
// interrupts, priority, mret, CSR rules, async reset during redirect).
module tb_trap_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic [31:0] exc_tval;
    logic        mret;
    logic        irq_msi, irq_mti, irq_mei;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [1:0]  priv;

    int errors = 0;
    int checks = 0;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;
    localparam logic [11:0] A_MIP     = 12'h344;

    trap_unit dut (
        .clk         (clk),
        .rst         (rst),
        .inst_valid  (inst_valid),
        .inst_pc     (inst_pc),
        .exc_valid   (exc_valid),
        .exc_code    (exc_code),
        .exc_tval    (exc_tval),
        .mret        (mret),
        .irq_msi     (irq_msi),
        .irq_mti     (irq_mti),
        .irq_mei     (irq_mei),
        .csr_addr    (csr_addr),
        .csr_we      (csr_we),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .csr_hit     (csr_hit),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .priv        (priv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rdchk(input string tag, input logic [11:0] a,
                         input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        inst_valid = 0; inst_pc = 0; exc_valid = 0; exc_code = 0;
        exc_tval = 0; mret = 0; csr_we = 0; csr_wdata = 0; csr_addr = 0;
    endtask

    // Drive one committing instruction, return 1ns after its edge.
    task automatic commit(input logic [31:0] pc, input logic exc,
                          input logic [3:0] code, input logic [31:0] tval,
                          input logic mr, input logic we,
                          input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        inst_valid = 1; inst_pc = pc; exc_valid = exc; exc_code = code;
        exc_tval = tval; mret = mr; csr_we = we; csr_addr = a;
        csr_wdata = d;
        go();
        clear();
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        commit(32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, a, d);
    endtask

    initial begin
        clear();
        irq_msi = 0; irq_mti = 0; irq_mei = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #2 rst = 0;

        // Reset state
        chk("rst_priv", {30'b0, priv}, 32'd3);
        chk("rst_redirect", {31'b0, redirect}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_rpc", redirect_pc, 32'h0);
        rdchk("rst_mtvec", A_MTVEC, 32'h100);
        rdchk("rst_mstatus", A_MSTATUS, 32'h1800);
        rdchk("rst_mepc", A_MEPC, 32'h0);
        rdchk("rst_mie", A_MIE, 32'h0);
        chk("hit_mtvec", {31'b0, csr_hit}, 32'd1);
        rdchk("unimpl_rdata", 12'h123, 32'h0);
        chk("unimpl_hit", {31'b0, csr_hit}, 32'd0);

        // Exception: MIE=1 beforehand so MPIE must capture it
        wr(A_MSTATUS, 32'h1808);
        commit(32'h2004, 1'b1, 4'd2, 32'h73, 1'b0, 1'b0, 12'h0, 32'h0);
        chk("exc_redirect", {31'b0, redirect}, 32'd1);
        chk("exc_stall", {31'b0, stall}, 32'd1);
        chk("exc_rpc", redirect_pc, 32'h100);
        rdchk("exc_mepc", A_MEPC, 32'h2004);
        rdchk("exc_mcause", A_MCAUSE, 32'h2);
        rdchk("exc_mtval", A_MTVAL, 32'h73);
        rdchk("exc_mstatus", A_MSTATUS, 32'h1880);
        go();
        chk("exc_pulse_end", {31'b0, redirect}, 32'd0);

        // Interrupt MTI, same-cycle CSR write dropped
        wr(A_MSTATUS, 32'h1808);
        wr(A_MIE, 32'hFFFF_FFFF);
        rdchk("mie_mask", A_MIE, 32'h888);
        wr(A_MIE, 32'h80);
        wr(A_MTVEC, 32'h101);
`ifdef TRAP_VECTORED_EN
        rdchk("mtvec_mode", A_MTVEC, 32'h101);
        wr(A_MTVEC, 32'h103);
        rdchk("mtvec_badmode", A_MTVEC, 32'h101);
`else
        rdchk("mtvec_mode", A_MTVEC, 32'h100);
`endif
        irq_mti = 1;
        rdchk("mip_mti", A_MIP, 32'h80);
        commit(32'h3000, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, A_MTVAL, 32'hDEAD);
        chk("irq_redirect", {31'b0, redirect}, 32'd1);
`ifdef TRAP_VECTORED_EN
        chk("irq_rpc", redirect_pc, 32'h11C);
`else
        chk("irq_rpc", redirect_pc, 32'h100);
`endif
        rdchk("irq_mcause", A_MCAUSE, 32'h8000_0007);
        rdchk("irq_mepc", A_MEPC, 32'h3000);
        rdchk("irq_mtval_dropwr", A_MTVAL, 32'h0);
        rdchk("irq_mstatus", A_MSTATUS, 32'h1880);
        go();
        wr(A_MTVEC, 32'h100);

        // MIE=0 in M-mode masks the still-pending interrupt
        wr(A_MTVAL, 32'h1234);
        chk("masked_noredirect", {31'b0, redirect}, 32'd0);
        rdchk("masked_wr", A_MTVAL, 32'h1234);

        // Priority: MEI > MSI > MTI; exception beats all
        wr(A_MIE, 32'h888);
        wr(A_MSTATUS, 32'h1808);
        irq_msi = 1; irq_mei = 1;
        commit(32'h3100, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        rdchk("prio_mei", A_MCAUSE, 32'h8000_000B);
        go();
        wr(A_MSTATUS, 32'h1808);
        commit(32'h3200, 1'b1, 4'd11, 32'h55, 1'b0, 1'b0, 12'h0, 32'h0);
        rdchk("prio_exc", A_MCAUSE, 32'hB);
        rdchk("prio_exc_tval", A_MTVAL, 32'h55);
        go();
        wr(A_MSTATUS, 32'h1808);
        irq_mei = 0;
        commit(32'h3300, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        rdchk("prio_msi", A_MCAUSE, 32'h8000_0003);
        go();
        irq_msi = 0; irq_mti = 0;
        wr(A_MIE, 32'h0);

        // mret to U-mode; second mret in REDIRECT ignored
        wr(A_MEPC, 32'h4003);
        rdchk("mepc_lowbits", A_MEPC, 32'h4000);
        wr(A_MSTATUS, 32'h80);
        rdchk("mstatus_mppu", A_MSTATUS, 32'h80);
        commit(32'h1234, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 12'h0, 32'h0);
        inst_valid = 1; mret = 1;
        chk("mret_redirect", {31'b0, redirect}, 32'd1);
        chk("mret_rpc", redirect_pc, 32'h4000);
        chk("mret_priv", {30'b0, priv}, 32'd0);
        go();
        clear();
        chk("mret_ignored", {31'b0, redirect}, 32'd0);
        rdchk("mret_mstatus", A_MSTATUS, 32'h88);

        // Interrupt in U-mode ignores MIE=0
        wr(A_MSTATUS, 32'h0);
        wr(A_MIE, 32'h8);
        irq_msi = 1;
        commit(32'h5007, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        chk("u_irq_redirect", {31'b0, redirect}, 32'd1);
        chk("u_irq_priv", {30'b0, priv}, 32'd3);
        rdchk("u_irq_mcause", A_MCAUSE, 32'h8000_0003);
        rdchk("u_irq_mepc", A_MEPC, 32'h5004);
        rdchk("u_irq_mstatus", A_MSTATUS, 32'h0);
        go();
        irq_msi = 0;
        wr(A_MIE, 32'h0);

        // mret with same-cycle mstatus write uses pre-write MPIE/MPP
        commit(32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1, A_MSTATUS, 32'h1880);
        chk("mretwr_rpc", redirect_pc, 32'h5004);
        chk("mretwr_priv", {30'b0, priv}, 32'd0);
        rdchk("mretwr_mstatus", A_MSTATUS, 32'h80);
        go();

        // Async reset during the REDIRECT cycle
        commit(32'h6000, 1'b1, 4'd2, 32'h1, 1'b0, 1'b0, 12'h0, 32'h0);
        chk("rr_redirect_pre", {31'b0, redirect}, 32'd1);
        #2 rst = 1;
        #1;
        chk("rr_redirect", {31'b0, redirect}, 32'd0);
        chk("rr_stall", {31'b0, stall}, 32'd0);
        chk("rr_rpc", redirect_pc, 32'h0);
        chk("rr_priv", {30'b0, priv}, 32'd3);
        rdchk("rr_mstatus", A_MSTATUS, 32'h1800);
        rdchk("rr_mepc", A_MEPC, 32'h0);
        rdchk("rr_mcause", A_MCAUSE, 32'h0);
        rdchk("rr_mtval", A_MTVAL, 32'h0);
        rdchk("rr_mtvec", A_MTVEC, 32'h100);
        rst = 0;
        go();
        chk("rr_after", {31'b0, redirect}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
